// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding fetch at a time, holds the fetched word
// until downstream consumes it, then advances sequentially or redirects on a branch.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] COUNT_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instr,
  output logic [5:0]  instr_op,
  output logic        instr_valid,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_e;

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] pc_plus4_q;
  logic [31:0] count_q;
  logic        req_q;
  logic        valid_q;

  logic [31:0] seq_pc_d;
  logic [31:0] redirect_pc_d;
  logic [31:0] next_pc_d;

  // Redirect targets are word-aligned by dropping the low two bits.
  assign seq_pc_d      = pc_q + 32'd4;
  assign redirect_pc_d = branch_target & 32'hFFFF_FFFC;
  assign next_pc_d     = branch_taken ? redirect_pc_d : seq_pc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC_ALIGNED;
      instr_q    <= 32'h0;
      pc_plus4_q <= 32'h0;
      count_q    <= COUNT_RESET;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
        FETCH: begin
          state_q <= WAIT;
          req_q   <= 1'b0;
        end
        WAIT: begin
          if (imem_valid) begin
            instr_q    <= imem_rdata;
            pc_plus4_q <= seq_pc_d;
            valid_q    <= 1'b1;
            state_q    <= HOLD;
          end
        end
        HOLD: begin
          // Branch inputs only matter on the cycle the held instruction leaves.
          if (!stall) begin
            pc_q    <= next_pc_d;
            count_q <= count_q + 32'd1;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state_q <= FETCH;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_op    = instr_q[31:26];
  assign instr_valid = valid_q;
  assign pc_plus4    = pc_plus4_q;
  assign instr_count = count_q;

endmodule
